sram_mem_ctrl: RTL and testbench

Multi-cycle controller that sits between the MEM pipeline stage and an external 16-bit asynchronous SRAM, replacing the single-cycle data memory array. It converts one 32-bit load/store from the MEM stage into two 16-bit SRAM half-word accesses with programmable wait states. It drives a ready signal that the hazard/freeze logic uses to stall every pipeline register until the access completes.

---
 rtl/sram_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle bridge from the MEM stage to a 16-bit asynchronous SRAM: each 32-bit access becomes two half-word phases.
// Optional access counters (rd_count/wr_count) are built when SRAM_ACC_CNT_EN is defined.
module sram_mem_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        rm_val,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_ACC_CNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] WLAST  = 4'(WAIT_CYCLES - 1);
    localparam bit         SINGLE = (WAIT_CYCLES == 1);

    state_t              state_reg,  state_next;
    logic [3:0]          wcnt_reg,   wcnt_next;
    logic [SRAM_AW-2:0]  widx_reg,   widx_next;
    logic [31:0]         wdata_reg,  wdata_next;
    logic                is_wr_reg,  is_wr_next;
    logic [31:0]         rd_data_reg, rd_data_next;
    logic [SRAM_AW-1:0]  addr_reg,   addr_next;
    logic [15:0]         dq_out_reg, dq_out_next;
    logic                oe_reg,     oe_next;
    logic                we_n_reg,   we_n_next;

    logic                req;
    logic [31:0]         offset;
    logic [SRAM_AW-2:0]  widx_in;
    logic                unused_offset_bits;

    assign req     = mem_r_en | mem_w_en;
    // Word index wraps modulo the SRAM size; byte lane bits are dropped.
    assign offset  = alu_res - 32'(BASE_ADDR);
    assign widx_in = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        widx_next    = widx_reg;
        wdata_next   = wdata_reg;
        is_wr_next   = is_wr_reg;
        rd_data_next = rd_data_reg;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    widx_next  = widx_in;
                    wdata_next = rm_val;
                    is_wr_next = mem_w_en;
                    wcnt_next  = 4'd0;
                    state_next = LO;
                end
            end
            LO: begin
                if (wcnt_reg == WLAST) begin
                    if (!is_wr_reg) begin
                        rd_data_next[15:0] = sram_dq_in;
                    end
                    wcnt_next  = 4'd0;
                    state_next = HI;
                end else begin
                    wcnt_next = wcnt_reg + 4'd1;
                end
            end
            HI: begin
                if (wcnt_reg == WLAST) begin
                    if (!is_wr_reg) begin
                        rd_data_next[31:16] = sram_dq_in;
                    end
                    wcnt_next  = 4'd0;
                    state_next = DONE;
                end else begin
                    wcnt_next = wcnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next-state view so they line up exactly with the phase cycles.
    always_comb begin
        addr_next   = addr_reg;
        dq_out_next = dq_out_reg;
        oe_next     = 1'b0;
        we_n_next   = 1'b1;

        case (state_next)
            LO: begin
                addr_next   = {widx_next, 1'b0};
                dq_out_next = wdata_next[15:0];
                oe_next     = is_wr_next;
                we_n_next   = ~(is_wr_next & (SINGLE | (wcnt_next != WLAST)));
            end
            HI: begin
                addr_next   = {widx_next, 1'b1};
                dq_out_next = wdata_next[31:16];
                oe_next     = is_wr_next;
                we_n_next   = ~(is_wr_next & (SINGLE | (wcnt_next != WLAST)));
            end
            default: begin
                oe_next   = 1'b0;
                we_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            wcnt_reg    <= 4'd0;
            widx_reg    <= '0;
            wdata_reg   <= 32'd0;
            is_wr_reg   <= 1'b0;
            rd_data_reg <= 32'd0;
            addr_reg    <= '0;
            dq_out_reg  <= 16'd0;
            oe_reg      <= 1'b0;
            we_n_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            widx_reg    <= widx_next;
            wdata_reg   <= wdata_next;
            is_wr_reg   <= is_wr_next;
            rd_data_reg <= rd_data_next;
            addr_reg    <= addr_next;
            dq_out_reg  <= dq_out_next;
            oe_reg      <= oe_next;
            we_n_reg    <= we_n_next;
        end
    end

    assign ready       = ((state_reg == IDLE) & ~req) | (state_reg == DONE);
    assign rd_data     = rd_data_reg;
    assign sram_addr   = addr_reg;
    assign sram_dq_out = dq_out_reg;
    assign sram_dq_oe  = oe_reg;
    assign sram_we_n   = we_n_reg;

`ifdef SRAM_ACC_CNT_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_reg <= 32'd0;
            wr_count_reg <= 32'd0;
        end else if (state_reg == DONE) begin
            if (is_wr_reg) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end else begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: one controller with two wait states, one with a single wait state, each behind a small SRAM model.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] alu   [2];
    logic [31:0] wv    [2];
    logic [31:0] rdd   [2];
    logic        rdy   [2];
    logic [17:0] sa    [2];
    logic [15:0] dqo   [2];
    logic [15:0] dqi   [2];
    logic        oe    [2];
    logic        wen   [2];
    logic [15:0] mem   [2][64];
`ifdef SRAM_ACC_CNT_EN
    logic [31:0] rdc   [2];
    logic [31:0] wrc   [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut0 (
        .clk(clk), .rst(rst),
        .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
        .alu_res(alu[0]), .rm_val(wv[0]),
        .rd_data(rdd[0]), .ready(rdy[0]),
        .sram_addr(sa[0]), .sram_dq_out(dqo[0]), .sram_dq_in(dqi[0]),
        .sram_dq_oe(oe[0]), .sram_we_n(wen[0])
`ifdef SRAM_ACC_CNT_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    sram_mem_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst),
        .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
        .alu_res(alu[1]), .rm_val(wv[1]),
        .rd_data(rdd[1]), .ready(rdy[1]),
        .sram_addr(sa[1]), .sram_dq_out(dqo[1]), .sram_dq_in(dqi[1]),
        .sram_dq_oe(oe[1]), .sram_we_n(wen[1])
`ifdef SRAM_ACC_CNT_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    // SRAM model: asynchronous read, write taken on a clock edge while we_n is low and the bus is driven.
    always @(posedge clk) begin
        if (rst) begin
            mem[0][2] <= 16'h5678;
            mem[0][3] <= 16'h1234;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (!wen[s] && oe[s]) mem[s][sa[s][5:0]] <= dqo[s];
            end
        end
    end

    assign dqi[0] = mem[0][sa[0][5:0]];
    assign dqi[1] = mem[1][sa[1][5:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int s = 0; s < 2; s++) begin
            r_en[s] = 1'b0;
            w_en[s] = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    // Runs one access; returns in the DONE cycle with the request still applied.
    task automatic access(input int s, input bit b2b, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [17:0] exp_lo);
        int wc;
        int nlow;
        int we_lo;
        int we_hi;
        int oe_n;
        logic [17:0] lo_addr;
        logic [17:0] hi_addr;
        logic [15:0] lo_dq;
        logic [15:0] hi_dq;
        wc = (s == 0) ? 2 : 1;
        nlow = 0; we_lo = 0; we_hi = 0; oe_n = 0;
        lo_addr = '1; hi_addr = '1; lo_dq = '0; hi_dq = '0;
        r_en[s] = r; w_en[s] = w; alu[s] = a; wv[s] = d;
        if (b2b) @(negedge clk);
        #1;
        for (int c = 0; c < 40; c++) begin
            if (rdy[s]) break;
            nlow++;
            if (c >= 1 && c <= wc) begin
                if (c == 1) begin lo_addr = sa[s]; lo_dq = dqo[s]; end
                if (!wen[s]) we_lo++;
            end else if (c > wc && c <= 2 * wc) begin
                if (c == wc + 1) begin hi_addr = sa[s]; hi_dq = dqo[s]; end
                if (!wen[s]) we_hi++;
            end
            if (oe[s]) oe_n++;
            @(negedge clk);
            #1;
        end
        $display("access dut%0d rd=%0b wr=%0b addr=%0d data=%h ready_low=%0d rd_data=%h",
                 s, r, w, a, d, nlow, rdd[s]);
        chk("ready_low_cycles", 32'(nlow), 32'(2 * wc + 1));
        chk("addr_lo", 32'(lo_addr), 32'(exp_lo));
        chk("addr_hi", 32'(hi_addr), 32'(exp_lo | 18'd1));
        chk("we_low_lo", 32'(we_lo), w ? 32'd1 : 32'd0);
        chk("we_low_hi", 32'(we_hi), w ? 32'd1 : 32'd0);
        chk("oe_cycles", 32'(oe_n), w ? 32'(2 * wc) : 32'd0);
        if (w) begin
            chk("dq_lo", 32'(lo_dq), 32'(d[15:0]));
            chk("dq_hi", 32'(hi_dq), 32'(d[31:16]));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            r_en[s] = 1'b0; w_en[s] = 1'b0; alu[s] = 32'd0; wv[s] = 32'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_rd_data", rdd[0], 32'd0);
        chk("rst_we_n", 32'(wen[0]), 32'd1);
        chk("rst_oe", 32'(oe[0]), 32'd0);
        chk("rst_addr", 32'(sa[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Store at the base address.
        access(0, 1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0);
        chk("mem0_lo", 32'(mem[0][0]), 32'h0000BEEF);
        chk("mem0_hi", 32'(mem[0][1]), 32'h0000DEAD);
        idle();

        // Load from preloaded half-words 2/3.
        access(0, 1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2);
        chk("load_rd_data", rdd[0], 32'h12345678);
        idle();

        // Both enables: behaves as a write, read data untouched.
        access(0, 1'b0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4);
        chk("both_mem_lo", 32'(mem[0][4]), 32'h0000F00D);
        chk("both_mem_hi", 32'(mem[0][5]), 32'h0000CAFE);
        chk("both_rd_hold", rdd[0], 32'h12345678);
        idle();

        // Back-to-back store then load at the same address.
        access(0, 1'b0, 1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, 18'd8);
        access(0, 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 18'd8);
        chk("b2b_rd_data", rdd[0], 32'h0BADC0DE);
        idle();

        // Address wrap, then reset during the high phase of a store.
        w_en[0] = 1'b1; alu[0] = 32'd1024 + 32'd4 * 32'd131072; wv[0] = 32'h33334444;
        @(negedge clk);
        #1;
        chk("wrap_addr_lo", 32'(sa[0]), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_addr_hi", 32'(sa[0]), 32'd1);
        chk("wrap_hi_we_n", 32'(wen[0]), 32'd0);
        chk("wrap_hi_oe", 32'(oe[0]), 32'd1);
        rst = 1'b1;
        w_en[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
        chk("mid_rst_we_n", 32'(wen[0]), 32'd1);
        chk("mid_rst_oe", 32'(oe[0]), 32'd0);
        chk("mid_rst_rd_data", rdd[0], 32'd0);
        chk("mid_rst_addr", 32'(sa[0]), 32'd0);
        chk("wrap_mem_lo", 32'(mem[0][0]), 32'h00004444);
        @(negedge clk);
        #1;

        // Single wait state: 3 loads and 2 stores.
        access(1, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 18'd4);
        idle();
        access(1, 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 18'd4);
        chk("w1_load_a", rdd[1], 32'hA5A55A5A);
        idle();
        access(1, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0F1E2D3C, 18'd6);
        idle();
        access(1, 1'b0, 1'b1, 1'b0, 32'd1036, 32'd0, 18'd6);
        chk("w1_load_b", rdd[1], 32'h0F1E2D3C);
        idle();
        access(1, 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 18'd4);
        chk("w1_load_c", rdd[1], 32'hA5A55A5A);
        idle();
`ifdef SRAM_ACC_CNT_EN
        chk("rd_count", rdc[1], 32'd3);
        chk("wr_count", wrc[1], 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
